// File: rtl/cas_writer.sv
// Cassette capture: decodes the console's FSK tape output into framed bytes and writes them to the CAS buffer RAM.
// One byte per wr_req/wr_ack handshake; a byte that completes while a request is still pending is dropped and flagged.
module cas_writer #(
    parameter logic [15:0] THRESH     = 16'd13333,
    parameter logic [15:0] MIN_PERIOD = 16'd2000,
    parameter logic [15:0] TIMEOUT    = 16'd40000,
    parameter logic [17:0] LEN_LIMIT  = 18'h3FFFF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ce,
    input  logic        i_tape_out,
    input  logic        i_record,
    input  logic        i_motor,
    input  logic        i_rewind,
    output logic        o_wr_req,
    output logic [17:0] o_wr_addr,
    output logic [7:0]  o_wr_data,
    input  logic        i_wr_ack,
    output logic [17:0] o_tape_len,
    output logic        o_busy,
    output logic        o_overrun,
    output logic        o_full
);

    typedef enum logic [2:0] {IDLE, SYNC, START, DATA, STOP} state_t;

    state_t      r_state, w_state_next;
    logic [1:0]  r_sync;
    logic        r_prev;
    logic [15:0] r_cnt;
    logic        r_bit_vld, r_bit;
    logic [4:0]  r_ones;
    logic [2:0]  r_bitn;
    logic [7:0]  r_shift;
    logic        r_wr_req, r_overrun, r_full;
    logic [17:0] r_wr_addr, r_tape_len;
    logic [7:0]  r_wr_data;

    logic        w_rise, w_accept, w_armed, w_timeout, w_byte_done, w_ack, w_full_next;
    logic [17:0] w_len_next;

    assign w_rise    = r_sync[1] & ~r_prev;
    assign w_accept  = w_rise && (r_cnt >= MIN_PERIOD);
    assign w_armed   = i_record & i_motor;
    assign w_timeout = (r_state != IDLE) && (r_cnt == TIMEOUT);
    assign w_ack     = i_wr_ack & r_wr_req;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync    <= 2'b00;
            r_prev    <= 1'b0;
            r_cnt     <= 16'd0;
            r_bit_vld <= 1'b0;
            r_bit     <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_tape_out};
            r_prev    <= r_sync[1];
            r_bit_vld <= w_accept;
            if (w_accept)
                r_bit <= (r_cnt < THRESH);
            // Glitch edges leave the counter running so the real period is still measured.
            if (w_accept)
                r_cnt <= 16'd0;
            else if (i_ce && r_cnt != 16'hFFFF)
                r_cnt <= r_cnt + 16'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_byte_done  = 1'b0;
        if (i_rewind || !w_armed) begin
            w_state_next = IDLE;
        end else if (w_timeout) begin
            w_state_next = SYNC;
        end else if (r_bit_vld) begin
            case (r_state)
                IDLE:  w_state_next = SYNC;
                SYNC:  if (!r_bit && r_ones == 5'd16) w_state_next = DATA;
                DATA:  if (r_bitn == 3'd7) w_state_next = STOP;
                STOP: begin
                    if (r_bit) begin
                        w_state_next = START;
                        w_byte_done  = 1'b1;
                    end else begin
                        w_state_next = SYNC;
                    end
                end
                START: if (!r_bit) w_state_next = DATA;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_ones  <= 5'd0;
            r_bitn  <= 3'd0;
            r_shift <= 8'd0;
        end else begin
            r_state <= w_state_next;
            if (r_state != SYNC)
                r_ones <= 5'd0;
            else if (r_bit_vld)
                r_ones <= !r_bit ? 5'd0 : (r_ones == 5'd16) ? 5'd16 : r_ones + 5'd1;
            if (r_state != DATA) begin
                r_bitn <= 3'd0;
            end else if (r_bit_vld) begin
                r_shift <= {r_bit, r_shift[7:1]};
                r_bitn  <= r_bitn + 3'd1;
            end
        end
    end

    // The final ack holds tape_len at the last address instead of wrapping.
    always_comb begin
        w_len_next  = r_tape_len;
        w_full_next = r_full;
        if (w_ack) begin
            if (r_tape_len == LEN_LIMIT)
                w_full_next = 1'b1;
            else
                w_len_next = r_tape_len + 18'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_req   <= 1'b0;
            r_wr_addr  <= 18'd0;
            r_wr_data  <= 8'd0;
            r_tape_len <= 18'd0;
            r_overrun  <= 1'b0;
            r_full     <= 1'b0;
        end else if (i_rewind) begin
            r_wr_req   <= 1'b0;
            r_tape_len <= 18'd0;
            r_overrun  <= 1'b0;
            r_full     <= 1'b0;
        end else begin
            r_tape_len <= w_len_next;
            r_full     <= w_full_next;
            if (w_ack)
                r_wr_req <= 1'b0;
            if (w_byte_done && !w_full_next) begin
                if (!r_wr_req || w_ack) begin
                    r_wr_req  <= 1'b1;
                    r_wr_addr <= w_len_next;
                    r_wr_data <= r_shift;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign o_wr_req   = r_wr_req;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_tape_len = r_tape_len;
    assign o_overrun  = r_overrun;
    assign o_full     = r_full;
    assign o_busy     = (r_state != IDLE);

endmodule

// File: tb/tb_cas_writer.sv
// Directed bench for cas_writer with scaled-down timing parameters and a 3-byte buffer.
module tb_cas_writer;

    localparam int ONE  = 12;
    localparam int ZERO = 40;

    logic        clk = 1'b0, reset = 1'b1, ce = 1'b0, tape = 1'b0;
    logic        record = 1'b0, motor = 1'b0, rewind = 1'b0, wr_ack = 1'b0;
    logic        wr_req, busy, overrun, full;
    logic [17:0] wr_addr, tape_len;
    logic [7:0]  wr_data;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0]  data;
        int          glitch;
        logic [17:0] addr;
        logic [17:0] len;
        logic        full;
    } vec_t;

    vec_t vecs[3];

    cas_writer #(
        .THRESH(16'd27), .MIN_PERIOD(16'd4), .TIMEOUT(16'd80), .LEN_LIMIT(18'd2)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_ce(ce), .i_tape_out(tape),
        .i_record(record), .i_motor(motor), .i_rewind(rewind),
        .o_wr_req(wr_req), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .i_wr_ack(wr_ack), .o_tape_len(tape_len), .o_busy(busy),
        .o_overrun(overrun), .o_full(full)
    );

    always #5 clk = ~clk;
    always @(negedge clk) ce = ~ce;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (2 * n) @(negedge clk);
    endtask

    task automatic send_period(input int p, input bit glitch);
        tape = 1'b1;
        if (glitch) begin
            tick(1);
            tape = 1'b0;
            tick(1);
            tape = 1'b1;
            tick(p / 2 - 2);
        end else begin
            tick(p / 2);
        end
        tape = 1'b0;
        tick(p - p / 2);
    endtask

    task automatic send_bit(input bit b);
        send_period(b ? ONE : ZERO, 1'b0);
    endtask

    // Silence long enough to force a timeout, then a run of sync ones.
    task automatic preamble();
        tick(100);
        repeat (20) send_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop, input int glitch_idx);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++)
            send_period(d[i] ? ONE : ZERO, i == glitch_idx);
        send_bit(stop);
    endtask

    task automatic wait_req(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (wr_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic do_ack();
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_rewind();
        rewind = 1'b1;
        repeat (2) @(negedge clk);
        rewind = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{data: 8'hA5, glitch: -1, addr: 18'd0, len: 18'd1, full: 1'b0};
        vecs[1] = '{data: 8'h5A, glitch: 3,  addr: 18'd1, len: 18'd2, full: 1'b0};
        vecs[2] = '{data: 8'h81, glitch: -1, addr: 18'd2, len: 18'd2, full: 1'b1};

        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_wr_req", wr_req, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_tape_len", tape_len, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_full", full, 0);

        record = 1'b1;
        motor  = 1'b1;

        // Single-byte captures, the last one filling the buffer.
        for (int v = 0; v < 3; v++) begin
            preamble();
            send_frame(vecs[v].data, 1'b1, vecs[v].glitch);
            send_bit(1'b1);
            wait_req("vec_req_seen");
            check("vec_addr", wr_addr, vecs[v].addr);
            check("vec_data", wr_data, vecs[v].data);
            check("vec_overrun", overrun, 0);
            check("vec_busy", busy, 1);
            do_ack();
            check("vec_req_clear", wr_req, 0);
            check("vec_tape_len", tape_len, vecs[v].len);
            check("vec_full", full, vecs[v].full);
        end

        // Buffer full: byte dropped silently.
        preamble();
        send_frame(8'h33, 1'b1, -1);
        send_bit(1'b1);
        tick(5);
        check("full_no_req", wr_req, 0);
        check("full_no_overrun", overrun, 0);
        check("full_len_hold", tape_len, 2);
        do_rewind();
        check("rewind_len", tape_len, 0);
        check("rewind_full", full, 0);
        check("rewind_busy", busy, 0);

        // Back-to-back bytes with the ack withheld.
        preamble();
        send_frame(8'h3C, 1'b1, -1);
        send_frame(8'hC3, 1'b1, -1);
        send_bit(1'b1);
        wait_req("ovr_req_seen");
        check("ovr_data", wr_data, 8'h3C);
        check("ovr_addr", wr_addr, 0);
        check("ovr_flag", overrun, 1);
        do_ack();
        check("ovr_len", tape_len, 1);
        check("ovr_req_clear", wr_req, 0);
        do_rewind();
        check("ovr_rewind_flag", overrun, 0);
        check("ovr_rewind_len", tape_len, 0);

        // Framing error: back to SYNC, so an unsynced frame must not be taken.
        preamble();
        send_frame(8'hE7, 1'b0, -1);
        send_frame(8'h00, 1'b1, -1);
        repeat (20) send_bit(1'b1);
        check("frm_no_req", wr_req, 0);
        check("frm_busy", busy, 1);
        send_frame(8'h96, 1'b1, -1);
        send_bit(1'b1);
        wait_req("frm_req_seen");
        check("frm_addr", wr_addr, 0);
        check("frm_data", wr_data, 8'h96);
        do_ack();
        check("frm_len", tape_len, 1);

        // A long gap mid-byte times out; the remaining bits must not form a byte.
        preamble();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_period(100, 1'b0);
        repeat (4) send_bit(1'b1);
        send_bit(1'b1);
        tick(5);
        check("tmo_no_req", wr_req, 0);
        check("tmo_busy", busy, 1);

        // Motor drops mid-byte with a request pending.
        preamble();
        send_frame(8'h11, 1'b1, -1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        motor = 1'b0;
        @(negedge clk);
        check("mot_busy", busy, 0);
        check("mot_req", wr_req, 1);
        check("mot_addr", wr_addr, 1);
        check("mot_data", wr_data, 8'h11);
        repeat (50) @(negedge clk);
        check("mot_req_held", wr_req, 1);
        do_ack();
        check("mot_len", tape_len, 2);
        check("mot_req_clear", wr_req, 0);
        motor = 1'b1;

        // Reset drops a pending request even with an ack present.
        preamble();
        send_frame(8'h44, 1'b1, -1);
        send_bit(1'b1);
        wait_req("rst2_req_seen");
        reset  = 1'b1;
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        check("rst2_req", wr_req, 0);
        check("rst2_len", tape_len, 0);
        check("rst2_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
